// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: branch/JR resolution, load-use and branch-operand interlocks,
// interrupt flush sequencing and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned REG_WIDTH    = 4,
  parameter int unsigned OP_WIDTH     = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] pcplus1_i,
  input  logic                  regwrite_i,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic                  memtoreg_i,
  input  logic [OP_WIDTH-1:0]   aluop_i,
  input  logic [REG_WIDTH-1:0]  regsrc1_i,
  input  logic [REG_WIDTH-1:0]  regsrc2_i,
  input  logic [REG_WIDTH-1:0]  regdst_i,
  input  logic                  use1_i,
  input  logic                  use2_i,
  input  logic [DATA_WIDTH-1:0] rdata1_i,
  input  logic [DATA_WIDTH-1:0] rdata2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  src2imm_i,
  input  logic [2:0]            brtype_i,
  input  logic                  stall_i,
  input  logic                  intcp_i,
  input  logic [DATA_WIDTH-1:0] epc_i,
  output logic                  ex_valid_o,
  output logic                  ex_regwrite_o,
  output logic                  ex_memread_o,
  output logic                  ex_memwrite_o,
  output logic                  ex_memtoreg_o,
  output logic [OP_WIDTH-1:0]   ex_aluop_o,
  output logic [DATA_WIDTH-1:0] ex_alusrc1_o,
  output logic [DATA_WIDTH-1:0] ex_alusrc2_o,
  output logic [DATA_WIDTH-1:0] ex_memdata_o,
  output logic [REG_WIDTH-1:0]  ex_regsrc1_o,
  output logic [REG_WIDTH-1:0]  ex_regsrc2_o,
  output logic [REG_WIDTH-1:0]  ex_regdst_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic                  hold_o,
  output logic                  flush_ifid_o,
  output logic                  branch_taken_o,
  output logic [DATA_WIDTH-1:0] branch_target_o
);

  localparam int unsigned FcntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FcntW-1:0] FcntLoad = FcntW'(FLUSH_CYCLES - 1);
  localparam logic [2:0] BrBeqz = 3'd1;
  localparam logic [2:0] BrBnez = 3'd2;
  localparam logic [2:0] BrB    = 3'd3;
  localparam logic [2:0] BrJr   = 3'd4;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic [OP_WIDTH-1:0]   aluop;
    logic [DATA_WIDTH-1:0] alusrc1;
    logic [DATA_WIDTH-1:0] alusrc2;
    logic [DATA_WIDTH-1:0] memdata;
    logic [REG_WIDTH-1:0]  regsrc1;
    logic [REG_WIDTH-1:0]  regsrc2;
    logic [REG_WIDTH-1:0]  regdst;
  } idex_t;

  state_e               state_q, state_d;
  logic [FcntW-1:0]     fcnt_q, fcnt_d;
  idex_t                idex_q, idex_d, issue;
  logic [DATA_WIDTH-1:0] epc_q;
  logic                 mem_load_q;
  logic [REG_WIDTH-1:0] mem_regdst_q;

  logic br_reads_rs1, br_cond, load_use, br_haz, hazard;

  // Branch decode and target; the target is shown even when not taken.
  always_comb begin
    br_reads_rs1 = 1'b0;
    br_cond      = 1'b0;
    unique case (brtype_i)
      BrBeqz: begin br_reads_rs1 = 1'b1; br_cond = (rdata1_i == '0); end
      BrBnez: begin br_reads_rs1 = 1'b1; br_cond = (rdata1_i != '0); end
      BrB:    br_cond = 1'b1;
      BrJr:   begin br_reads_rs1 = 1'b1; br_cond = 1'b1; end
      default: ;
    endcase
    branch_target_o = (brtype_i == BrJr) ? rdata1_i : pcplus1_i + imm_i;
  end

  // A branch reading a load result needs it past MEM, hence the one-stage load record.
  always_comb begin
    load_use = idex_q.valid && idex_q.regwrite && idex_q.memread &&
               ((use1_i && regsrc1_i == idex_q.regdst) ||
                (use2_i && regsrc2_i == idex_q.regdst));
    br_haz   = br_reads_rs1 &&
               ((idex_q.valid && idex_q.regwrite && regsrc1_i == idex_q.regdst) ||
                (mem_load_q && regsrc1_i == mem_regdst_q));
    hazard   = valid_i && (load_use || br_haz);
  end

  always_comb begin
    issue         = '0;
    issue.valid   = valid_i;
    if (valid_i) begin
      issue.regwrite = regwrite_i;
      issue.memread  = memread_i;
      issue.memwrite = memwrite_i;
      issue.memtoreg = memtoreg_i;
      issue.aluop    = aluop_i;
    end
    issue.alusrc1 = rdata1_i;
    issue.alusrc2 = src2imm_i ? imm_i : rdata2_i;
    issue.memdata = rdata2_i;
    issue.regsrc1 = regsrc1_i;
    issue.regsrc2 = regsrc2_i;
    issue.regdst  = regdst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (intcp_i) begin
      fcnt_d  = FcntLoad;
      state_d = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else if (state_q == StFlush) begin
      if (fcnt_q == '0) state_d = StRun;
      else              fcnt_d  = fcnt_q - 1'b1;
    end
  end

  always_comb begin
    hold_o         = 1'b0;
    flush_ifid_o   = 1'b0;
    branch_taken_o = 1'b0;
    idex_d         = idex_q;
    if (intcp_i || state_q == StFlush) begin
      flush_ifid_o = 1'b1;
      idex_d       = '0;
    end else if (stall_i) begin
      hold_o = 1'b1;
    end else if (hazard) begin
      hold_o = 1'b1;
      idex_d = '0;
    end else begin
      branch_taken_o = valid_i && br_cond;
      flush_ifid_o   = valid_i && br_cond;
      idex_d         = issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q       <= '0;
      epc_q        <= '0;
      mem_load_q   <= 1'b0;
      mem_regdst_q <= '0;
    end else begin
      idex_q <= idex_d;
      if (intcp_i) epc_q <= epc_i;
      if (!stall_i) begin
        mem_load_q   <= idex_q.valid && idex_q.regwrite && idex_q.memread;
        mem_regdst_q <= idex_q.regdst;
      end
    end
  end

  assign ex_valid_o    = idex_q.valid;
  assign ex_regwrite_o = idex_q.regwrite;
  assign ex_memread_o  = idex_q.memread;
  assign ex_memwrite_o = idex_q.memwrite;
  assign ex_memtoreg_o = idex_q.memtoreg;
  assign ex_aluop_o    = idex_q.aluop;
  assign ex_alusrc1_o  = idex_q.alusrc1;
  assign ex_alusrc2_o  = idex_q.alusrc2;
  assign ex_memdata_o  = idex_q.memdata;
  assign ex_regsrc1_o  = idex_q.regsrc1;
  assign ex_regsrc2_o  = idex_q.regsrc2;
  assign ex_regdst_o   = idex_q.regdst;
  assign epc_o         = epc_q;

endmodule
